// File: rtl/psimd_add_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psimd_add_arbiter_pkg
// Brief    : Shared constants and types for the packed saturating add ALU
//            and its two-requester arbiter.
// Revision : 1.0  initial release
// ============================================================================
package psimd_add_arbiter_pkg;

    localparam int          LANE_W  = 8;
    localparam int          LANES   = 2;
    localparam int          WORD_W  = LANE_W * LANES;
    localparam logic [7:0]  SAT_POS = 8'h7F;
    localparam logic [7:0]  SAT_NEG = 8'h80;

    // Result-register occupancy
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } res_state_t;

endpackage : psimd_add_arbiter_pkg
`default_nettype wire

// File: rtl/psimd_add_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : psimd_add_arbiter_if
// Brief    : Requester/consumer bus of the shared packed-add arbiter.
//            master = requesters + result consumer, slave = arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface psimd_add_arbiter_if;
    import psimd_add_arbiter_pkg::*;

    logic              req0_valid;
    logic              req1_valid;
    logic [WORD_W-1:0] req0_a;
    logic [WORD_W-1:0] req0_b;
    logic [WORD_W-1:0] req1_a;
    logic [WORD_W-1:0] req1_b;
    logic              req0_ready;
    logic              req1_ready;
    logic              res_valid;
    logic [WORD_W-1:0] res_sum;
    logic              res_id;
    logic [LANES-1:0]  res_sat;
    logic              res_ready;

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_sum, res_id, res_sat
    );

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_sum, res_id, res_sat
    );

endinterface : psimd_add_arbiter_if
`default_nettype wire

// File: rtl/psimd_add_arbiter_paddsb.sv
`default_nettype none
// ============================================================================
// Module   : paddsb
// Brief    : Packed signed-byte saturating adder, two 8-bit lanes.
//            Positive overflow clamps to 0x7F, negative to 0x80.
// Revision : 1.0  initial release
// ============================================================================
module paddsb
    import psimd_add_arbiter_pkg::*;
(
    input  wire logic [WORD_W-1:0] i_a,
    input  wire logic [WORD_W-1:0] i_b,
    output logic      [WORD_W-1:0] o_sum,
    output logic      [LANES-1:0]  o_sat
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [LANE_W-1:0] w_a;
        logic [LANE_W-1:0] w_b;
        logic [LANE_W-1:0] w_wrap;
        logic              w_ovf;

        assign w_a    = i_a[i*LANE_W +: LANE_W];
        assign w_b    = i_b[i*LANE_W +: LANE_W];
        assign w_wrap = w_a + w_b;
        // Overflow only when both operands share a sign the wrap sum lost
        assign w_ovf  = (w_a[LANE_W-1] == w_b[LANE_W-1]) &&
                        (w_wrap[LANE_W-1] != w_a[LANE_W-1]);

        assign o_sum[i*LANE_W +: LANE_W] = w_ovf ? (w_a[LANE_W-1] ? SAT_NEG : SAT_POS)
                                                 : w_wrap;
        assign o_sat[i] = w_ovf;
    end

endmodule : paddsb
`default_nettype wire

// File: rtl/psimd_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : psimd_add_arbiter
// Brief    : Round-robin arbiter sharing one packed saturating adder between
//            two requesters, with a one-entry result register and
//            per-requester saturation-event counters.
// Revision : 1.0  initial release
// ============================================================================
module psimd_add_arbiter
    import psimd_add_arbiter_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    psimd_add_arbiter_if.slave    bus,
    input  wire logic             clr_cnt,
    output logic      [CNT_W-1:0] sat_cnt0,
    output logic      [CNT_W-1:0] sat_cnt1
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    res_state_t        r_state;
    logic              r_ptr;      // requester favoured when both are valid
    logic [WORD_W-1:0] r_sum;
    logic              r_id;
    logic [LANES-1:0]  r_sat;
    logic [CNT_W-1:0]  r_cnt0;
    logic [CNT_W-1:0]  r_cnt1;

    logic              w_slot_free;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_grant;
    logic [WORD_W-1:0] w_op_a;
    logic [WORD_W-1:0] w_op_b;
    logic [WORD_W-1:0] w_sum;
    logic [LANES-1:0]  w_sat;
    logic              w_any_sat;

    // Grant: slot must be free (empty, or draining this cycle); never in reset
    assign w_slot_free = (r_state == ST_EMPTY) || bus.res_ready;
    assign w_grant0    = !rst && w_slot_free && bus.req0_valid &&
                         (!bus.req1_valid || (r_ptr == 1'b0));
    assign w_grant1    = !rst && w_slot_free && bus.req1_valid &&
                         (!bus.req0_valid || (r_ptr == 1'b1));
    assign w_grant     = w_grant0 || w_grant1;

    // Operand mux steered by the grant; non-granted operands never reach the adder
    assign w_op_a = w_grant1 ? bus.req1_a : bus.req0_a;
    assign w_op_b = w_grant1 ? bus.req1_b : bus.req0_b;

    paddsb u_paddsb (
        .i_a   (w_op_a),
        .i_b   (w_op_b),
        .o_sum (w_sum),
        .o_sat (w_sat)
    );

    assign w_any_sat = |w_sat;

    // Result-register FSM and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_ptr   <= 1'b0;
            r_sum   <= '0;
            r_id    <= 1'b0;
            r_sat   <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_grant) r_state <= ST_FULL;
                end
                ST_FULL: begin
                    if (bus.res_ready && !w_grant) r_state <= ST_EMPTY;
                end
                default: r_state <= ST_EMPTY;
            endcase
            if (w_grant) begin
                r_sum <= w_sum;
                r_id  <= w_grant1;
                r_sat <= w_sat;
                r_ptr <= ~w_grant1;   // hand priority to the loser
            end
        end
    end

    // Saturation-event counters; clear wins over increment, no wrap at max
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_grant0 && w_any_sat && (r_cnt0 != c_CNT_MAX))
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (w_grant1 && w_any_sat && (r_cnt1 != c_CNT_MAX))
                r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end

    assign bus.req0_ready = w_grant0;
    assign bus.req1_ready = w_grant1;
    assign bus.res_valid  = (r_state == ST_FULL);
    assign bus.res_sum    = r_sum;
    assign bus.res_id     = r_id;
    assign bus.res_sat    = r_sat;
    assign sat_cnt0       = r_cnt0;
    assign sat_cnt1       = r_cnt1;

endmodule : psimd_add_arbiter
`default_nettype wire

// File: tb/tb_psimd_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_psimd_add_arbiter
// Brief    : Directed self-checking bench for psimd_add_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_psimd_add_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr_cnt;
    logic [7:0] sat_cnt0;
    logic [7:0] sat_cnt1;
    int         checks = 0;
    int         errors = 0;

    psimd_add_arbiter_if bus ();

    psimd_add_arbiter #(.CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .clr_cnt  (clr_cnt),
        .sat_cnt0 (sat_cnt0),
        .sat_cnt1 (sat_cnt1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                           input logic v1, input logic [15:0] a1, input logic [15:0] b1);
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    endtask

    // Absolute time bound so the run always terminates
    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        clr_cnt = 1'b0;
        bus.res_ready = 1'b1;
        set_req(1'b1, 16'h0101, 16'h0101, 1'b1, 16'h0101, 16'h0101);
        tick();
        tick();
        // Reset state and no grants while in reset
        chk("rst_ready0", 32'(bus.req0_ready), 32'h0);
        chk("rst_ready1", 32'(bus.req1_ready), 32'h0);
        chk("rst_valid",  32'(bus.res_valid), 32'h0);
        chk("rst_sum",    32'(bus.res_sum), 32'h0);
        chk("rst_id",     32'(bus.res_id), 32'h0);
        chk("rst_sat",    32'(bus.res_sat), 32'h0);
        chk("rst_cnt0",   32'(sat_cnt0), 32'h0);
        chk("rst_cnt1",   32'(sat_cnt1), 32'h0);
        rst = 1'b0;
        set_req(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        tick();

        // Positive hi-lane saturation from req0
        set_req(1'b1, 16'h7F01, 16'h0101, 1'b0, 16'h0, 16'h0);
        #1 chk("p_ready0", 32'(bus.req0_ready), 32'h1);
        tick();
        set_req(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        chk("p_valid", 32'(bus.res_valid), 32'h1);
        chk("p_sum",   32'(bus.res_sum), 32'h7F02);
        chk("p_sat",   32'(bus.res_sat), 32'h2);
        chk("p_id",    32'(bus.res_id), 32'h0);
        chk("p_cnt0",  32'(sat_cnt0), 32'h1);
        tick();
        chk("drain_empty", 32'(bus.res_valid), 32'h0);

        // Negative saturation from req1
        set_req(1'b0, 16'h0, 16'h0, 1'b1, 16'h80F0, 16'hFF05);
        #1 chk("n_ready1", 32'(bus.req1_ready), 32'h1);
        tick();
        chk("n1_sum", 32'(bus.res_sum), 32'h80F5);
        chk("n1_sat", 32'(bus.res_sat), 32'h2);
        chk("n1_id",  32'(bus.res_id), 32'h1);
        chk("n1_cnt1", 32'(sat_cnt1), 32'h1);
        set_req(1'b0, 16'h0, 16'h0, 1'b1, 16'h8080, 16'hFFFF);
        tick();
        chk("n2_sum", 32'(bus.res_sum), 32'h8080);
        chk("n2_sat", 32'(bus.res_sat), 32'h3);
        chk("n2_cnt1", 32'(sat_cnt1), 32'h2);
        chk("n2_cnt0", 32'(sat_cnt0), 32'h1);
        set_req(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        tick();

        // Round robin with both valid from the first cycle after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(1'b1, 16'h0101, 16'h0101, 1'b1, 16'h1010, 16'h0101);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready0", 32'(bus.req0_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("rr_ready1", 32'(bus.req1_ready), (i % 2 == 0) ? 32'h0 : 32'h1);
            tick();
            chk("rr_valid", 32'(bus.res_valid), 32'h1);
            chk("rr_id",    32'(bus.res_id), (i % 2 == 0) ? 32'h0 : 32'h1);
            chk("rr_sum",   32'(bus.res_sum), (i % 2 == 0) ? 32'h0202 : 32'h1111);
        end

        // Backpressure: FULL holding req1's result, pointer now at req0
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready0", 32'(bus.req0_ready), 32'h0);
            chk("bp_ready1", 32'(bus.req1_ready), 32'h0);
            tick();
            chk("bp_valid", 32'(bus.res_valid), 32'h1);
            chk("bp_id",    32'(bus.res_id), 32'h1);
            chk("bp_sum",   32'(bus.res_sum), 32'h1111);
            chk("bp_sat",   32'(bus.res_sat), 32'h0);
        end
        bus.res_ready = 1'b1;
        #1 chk("refill_ready0", 32'(bus.req0_ready), 32'h1);
        tick();
        chk("refill_valid", 32'(bus.res_valid), 32'h1);
        chk("refill_id",    32'(bus.res_id), 32'h0);
        chk("refill_sum",   32'(bus.res_sum), 32'h0202);
        set_req(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        tick();
        chk("bp_drain", 32'(bus.res_valid), 32'h0);

        // Counter saturation at 255 after 260 saturating adds
        set_req(1'b1, 16'h7F01, 16'h0101, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 260; i++) begin
            tick();
            if (i == 99) chk("cnt0_100", 32'(sat_cnt0), 32'd100);
        end
        chk("cnt0_max", 32'(sat_cnt0), 32'd255);
        clr_cnt = 1'b1;
        tick();
        chk("clr_prio", 32'(sat_cnt0), 32'h0);
        clr_cnt = 1'b0;
        tick();
        chk("cnt0_after_clr", 32'(sat_cnt0), 32'h1);

        // Reset while FULL with res_ready low and pointer at req1
        set_req(1'b0, 16'h0, 16'h0, 1'b1, 16'h7F01, 16'h0101);
        tick();                                   // grant 1, pointer -> 0
        chk("pre_cnt1", 32'(sat_cnt1), 32'h1);
        set_req(1'b1, 16'h7F01, 16'h0101, 1'b0, 16'h0, 16'h0);
        tick();                                   // grant 0, pointer -> 1
        bus.res_ready = 1'b0;
        set_req(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        tick();
        chk("pre_full", 32'(bus.res_valid), 32'h1);
        chk("pre_cnt0", 32'(sat_cnt0), 32'h2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(bus.res_valid), 32'h0);
        chk("mid_rst_cnt0",  32'(sat_cnt0), 32'h0);
        chk("mid_rst_cnt1",  32'(sat_cnt1), 32'h0);
        chk("mid_rst_sum",   32'(bus.res_sum), 32'h0);
        bus.res_ready = 1'b1;
        set_req(1'b1, 16'h0303, 16'h0101, 1'b1, 16'h0505, 16'h0101);
        #1;
        chk("ptr_ready0", 32'(bus.req0_ready), 32'h1);
        chk("ptr_ready1", 32'(bus.req1_ready), 32'h0);
        tick();
        chk("ptr_id",  32'(bus.res_id), 32'h0);
        chk("ptr_sum", 32'(bus.res_sum), 32'h0404);
        set_req(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_psimd_add_arbiter
`default_nettype wire

// File: doc/psimd_add_arbiter.md
PSIMD_ADD_ARBITER -- requirements
Module: psimd_add_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of each per-requester saturation-event counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester N presents an operand pair.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  16  packed operands, two signed 8-bit lanes each ([15:8] hi, [7:0] lo).
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  operand pair of requester N accepted this cycle.
REQ-007 SHALL have port res_valid  output  1  result register holds a valid result.
REQ-008 SHALL have port res_sum  output  16  packed saturating sum.
REQ-009 SHALL have port res_id  output  1  requester that issued the result (0/1).
REQ-010 SHALL have port res_sat  output  2  lane saturated flags {hi, lo}.
REQ-011 SHALL have port res_ready  input  1  consumer takes the result.
REQ-012 SHALL have ports sat_cnt0/sat_cnt1  output  CNT_W  per-requester saturation-event counts.
REQ-013 SHALL have port clr_cnt  input  1  synchronous clear of both counters.

Function
REQ-014 SHALL share one packed saturating adder between both requesters; per lane, positive overflow -> 0x7F, negative overflow -> 0x80, otherwise the 8-bit wrap sum.
REQ-015 SHALL keep a one-entry result register with states EMPTY and FULL; slot_free = EMPTY or (FULL and res_ready).
REQ-016 SHALL grant at most one requester per cycle, only when slot_free and that requester is valid; reqN_ready = grant to N (combinational, no dependence on reqN_ready).
REQ-017 SHALL arbitrate round-robin: one valid -> that one; both valid -> requester named by priority pointer; after every grant the pointer moves to the non-granted requester.
REQ-018 SHALL load res_sum, res_id, res_sat from the granted operands on the grant edge; res_valid rises the next cycle (latency 1 from accept).
REQ-019 SHALL set a lane's res_sat bit when both operand sign bits are equal and the 8-bit wrap sum sign differs.
REQ-020 SHALL sustain one result per cycle: drain (res_ready) and refill (grant) in the same cycle leave the state FULL with new contents.
REQ-021 SHALL hold res_sum/res_id/res_sat stable while FULL and res_ready low; FULL with res_ready and no grant -> EMPTY.
REQ-022 SHALL increment sat_cntN on a grant to N with any res_sat bit set, saturating at all-ones (no wrap).
REQ-023 SHALL give clr_cnt priority over a same-cycle increment (counter -> 0).
REQ-024 SHALL ignore operands of non-granted requesters; a requester dropping valid before grant loses nothing.

Reset
REQ-025 SHALL on rst force: state EMPTY, res_valid 0, res_sum 0x0000, res_id 0, res_sat 2'b00, priority pointer -> requester 0, sat_cnt0/1 0.
REQ-026 SHALL assert no reqN_ready during a reset cycle; a pending result is discarded by reset mid-operation.

Structure
REQ-027 SHALL place state encoding (EMPTY/FULL), lane width 8, and saturation constants 0x7F/0x80 in the shared ALU package.
REQ-028 SHALL instantiate the existing paddsb module once as the datapath, fed by a grant-controlled operand mux; arbiter, result register, and counters stay in this module.

Verification
REQ-029 SHALL cover: req0 0x7F01 + 0x0101 -> next cycle res_valid 1, res_sum 0x7F02, res_sat 2'b10, res_id 0, sat_cnt0 1.
REQ-030 SHALL cover: req1 0x80F0 + 0xFF05 -> res_sum 0x80F5, res_sat 2'b10; 0x8080 + 0xFFFF -> 0x8080, res_sat 2'b11.
REQ-031 SHALL cover: both valid from first cycle after reset, res_ready 1 -> grants alternate 0,1,0,1; one result per cycle.
REQ-032 SHALL cover: res_ready low 3 cycles while FULL -> both readies 0, outputs stable; res_ready high -> drain plus refill in same cycle.
REQ-033 SHALL cover: 260 saturating adds from req0 -> sat_cnt0 holds 255; clr_cnt concurrent with increment -> 0.
REQ-034 SHALL cover: rst asserted while FULL and res_ready low -> next cycle res_valid 0, counters 0, pointer at req0.
